// File: rtl/bus_demux_pkg.sv
// bus_demux_pkg: shared types and constants for the 1-to-8 bus demultiplexer.
package bus_demux_pkg;

  localparam int unsigned NUM_TARGETS   = 8;
  localparam int unsigned SEL_W         = 3;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned ADR_W         = 16;
  localparam int unsigned BE_W          = 2;
  localparam int unsigned CNT_W         = 8;
  localparam int unsigned TO_CYCLES_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Request fields latched in IDLE and broadcast to all targets
  typedef struct packed {
    logic              we;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] dat;
    logic [BE_W-1:0]   be;
  } req_t;

  // Target index to one-hot strobe vector
  function automatic logic [NUM_TARGETS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    sel_onehot = NUM_TARGETS'(1) << sel;
  endfunction

endpackage

// File: rtl/mux8_16.sv
// mux8_16: combinational 8:1 selector of 16-bit words.
module mux8_16
  import bus_demux_pkg::*;
(
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [DATA_W-1:0] i_d0,
  input  logic [DATA_W-1:0] i_d1,
  input  logic [DATA_W-1:0] i_d2,
  input  logic [DATA_W-1:0] i_d3,
  input  logic [DATA_W-1:0] i_d4,
  input  logic [DATA_W-1:0] i_d5,
  input  logic [DATA_W-1:0] i_d6,
  input  logic [DATA_W-1:0] i_d7,
  output logic [DATA_W-1:0] o_y_c
);

  // Select one of eight inputs
  always_comb begin
    o_y_c = i_d0;
    case (i_sel)
      3'd0:    o_y_c = i_d0;
      3'd1:    o_y_c = i_d1;
      3'd2:    o_y_c = i_d2;
      3'd3:    o_y_c = i_d3;
      3'd4:    o_y_c = i_d4;
      3'd5:    o_y_c = i_d5;
      3'd6:    o_y_c = i_d6;
      default: o_y_c = i_d7;
    endcase
  end

endmodule

// File: rtl/bus_demux8_16.sv
// bus_demux8_16: registered 1-to-8 bus demultiplexer (IDLE -> BUSY -> DONE).
// Optional BUSY timeout abort enabled by defining BUS_DEMUX_TIMEOUT_EN.
module bus_demux8_16
  import bus_demux_pkg::*;
#(
  parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m_stb_i,
  input  logic                          m_we_i,
  input  logic [SEL_W-1:0]              m_sel_i,
  input  logic [ADR_W-1:0]              m_adr_i,
  input  logic [DATA_W-1:0]             m_dat_i,
  input  logic [BE_W-1:0]               m_byte_i,
  output logic [DATA_W-1:0]             m_dat_o,
  output logic                          m_ack_o,
  output logic                          m_err_o,
  output logic [NUM_TARGETS-1:0]        s_stb_o,
  output logic                          s_we_o,
  output logic [ADR_W-1:0]              s_adr_o,
  output logic [DATA_W-1:0]             s_dat_o,
  output logic [BE_W-1:0]               s_byte_o,
  input  logic [NUM_TARGETS*DATA_W-1:0] s_dat_i,
  input  logic [NUM_TARGETS-1:0]        s_ack_i
);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [SEL_W-1:0]         r_sel;
  req_t                     r_req;
  logic [NUM_TARGETS-1:0]   r_stb;
  logic                     r_ack;
  logic [DATA_W-1:0]        r_rdat;
  logic [DATA_W-1:0]        w_rdata_c;
  logic                     w_sel_ack;
  logic                     w_to_hit;
  logic                     w_capture;
  logic                     w_complete;
  logic                     w_timeout;

  assign w_sel_ack = s_ack_i[r_sel];

  // Read return path selected by the latched target index
  mux8_16 u_rmux (
    .i_sel (r_sel),
    .i_d0  (s_dat_i[0*DATA_W +: DATA_W]),
    .i_d1  (s_dat_i[1*DATA_W +: DATA_W]),
    .i_d2  (s_dat_i[2*DATA_W +: DATA_W]),
    .i_d3  (s_dat_i[3*DATA_W +: DATA_W]),
    .i_d4  (s_dat_i[4*DATA_W +: DATA_W]),
    .i_d5  (s_dat_i[5*DATA_W +: DATA_W]),
    .i_d6  (s_dat_i[6*DATA_W +: DATA_W]),
    .i_d7  (s_dat_i[7*DATA_W +: DATA_W]),
    .o_y_c (w_rdata_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and transfer event decode; a selected ack beats the timeout
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (m_stb_i) begin
          w_capture   = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_sel_ack) begin
          w_complete  = 1'b1;
          w_state_nxt = DONE;
        end else if (w_to_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Holding registers, strobe, ack pulse and read data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel  <= '0;
      r_req  <= '0;
      r_stb  <= '0;
      r_ack  <= 1'b0;
      r_rdat <= '0;
    end else begin
      r_ack <= w_complete;
      if (w_capture) begin
        r_sel  <= m_sel_i;
        r_req  <= '{we: m_we_i, adr: m_adr_i, dat: m_dat_i, be: m_byte_i};
        r_stb  <= sel_onehot(m_sel_i);
      end else if (w_complete || w_timeout) begin
        r_stb <= '0;
      end
      if (w_complete && !r_req.we) r_rdat <= w_rdata_c;
      if (w_timeout && !r_req.we)  r_rdat <= '1;
    end
  end

`ifdef BUS_DEMUX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYCLES - 1);

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_err;

  // BUSY cycle counter, cleared on entry to BUSY
  always_ff @(posedge clk) begin
    if (rst)                    r_to_cnt <= '0;
    else if (w_capture)         r_to_cnt <= '0;
    else if (r_state == BUSY)   r_to_cnt <= r_to_cnt + CNT_W'(1);
  end

  // Timeout error pulse
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_timeout;
  end

  assign w_to_hit = (r_to_cnt == TO_LAST);
  assign m_err_o  = r_err;
`else
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYCLES - 1);

  logic [CNT_W-1:0] w_unused_to;

  assign w_unused_to = TO_LAST;
  assign w_to_hit    = 1'b0;
  assign m_err_o     = 1'b0;
`endif

  assign m_dat_o  = r_rdat;
  assign m_ack_o  = r_ack;
  assign s_stb_o  = r_stb;
  assign s_we_o   = r_req.we;
  assign s_adr_o  = r_req.adr;
  assign s_dat_o  = r_req.dat;
  assign s_byte_o = r_req.be;

endmodule

// File: tb/tb_bus_demux8_16.sv
// tb_bus_demux8_16: directed, table-driven bench for bus_demux8_16.
module tb_bus_demux8_16;

`ifdef BUS_DEMUX_TIMEOUT_EN
  localparam int unsigned TB_TO = 4;
`else
  localparam int unsigned TB_TO = 255;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         m_stb_i;
  logic         m_we_i;
  logic [2:0]   m_sel_i;
  logic [15:0]  m_adr_i;
  logic [15:0]  m_dat_i;
  logic [1:0]   m_byte_i;
  logic [15:0]  m_dat_o;
  logic         m_ack_o;
  logic         m_err_o;
  logic [7:0]   s_stb_o;
  logic         s_we_o;
  logic [15:0]  s_adr_o;
  logic [15:0]  s_dat_o;
  logic [1:0]   s_byte_o;
  logic [127:0] s_dat_i;
  logic [7:0]   s_ack_i;

  int n_tests = 0;
  int n_fail  = 0;
  bit inv_en  = 1'b0;

  bus_demux8_16 #(.TO_CYCLES(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i), .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i), .m_byte_i(m_byte_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .m_err_o(m_err_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_byte_o(s_byte_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  sel;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [1:0]  be;
    int          waits;
    logic [15:0] rdata;
    logic [7:0]  exp_stb;
    logic [15:0] exp_mdat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Selected slice carries rdata, the others carry a distinct pattern
  function automatic logic [127:0] build_dat(input logic [2:0] sel, input logic [15:0] rdata);
    logic [127:0] d;
    for (int k = 0; k < 8; k++) begin
      if (k == int'(sel)) d[16*k +: 16] = rdata;
      else                d[16*k +: 16] = 16'(16'h1111 * k);
    end
    return d;
  endfunction

  // Invariants: strobe zero-or-one-hot, ack/err never together
  always @(negedge clk) begin
    if (inv_en) begin
      n_tests++;
      if (!$onehot0(s_stb_o) || (m_ack_o && m_err_o)) begin
        n_fail++;
        $display("FAIL invariant: stb=%h ack=%b err=%b", s_stb_o, m_ack_o, m_err_o);
      end
    end
  end

  initial begin
    int err_cnt;
    int err_cyc;
    int bad;

    vecs[0] = '{1'b1, 3'd5, 16'h1234, 16'hBEEF, 2'b11, 0, 16'h0000, 8'h20, 16'h0000};
    vecs[1] = '{1'b0, 3'd2, 16'h0040, 16'h0000, 2'b11, 3, 16'hA55A, 8'h04, 16'hA55A};
    vecs[2] = '{1'b0, 3'd0, 16'h0002, 16'h0000, 2'b01, 0, 16'h1357, 8'h01, 16'h1357};
    vecs[3] = '{1'b1, 3'd7, 16'hFFFE, 16'h0F0F, 2'b01, 1, 16'h9999, 8'h80, 16'h1357};
    vecs[4] = '{1'b0, 3'd7, 16'h8000, 16'h0000, 2'b10, 2, 16'hFEDC, 8'h80, 16'hFEDC};
    vecs[5] = '{1'b0, 3'd4, 16'h0100, 16'h0000, 2'b11, 0, 16'h0001, 8'h10, 16'h0001};
    vecs[6] = '{1'b1, 3'd3, 16'h00AA, 16'h5555, 2'b10, 0, 16'h7777, 8'h08, 16'h0001};

    rst = 1'b1; m_stb_i = 1'b0; m_we_i = 1'b0; m_sel_i = '0; m_adr_i = '0;
    m_dat_i = '0; m_byte_i = '0; s_dat_i = '0; s_ack_i = '0;
    step(); step();
    chk("reset stb", 32'(s_stb_o), 32'h0);
    chk("reset ack", 32'(m_ack_o), 32'h0);
    chk("reset err", 32'(m_err_o), 32'h0);
    chk("reset mdat", 32'(m_dat_o), 32'h0);
    chk("reset sadr", 32'({s_we_o, s_adr_o, s_dat_o, s_byte_o}), 32'h0);
    rst = 1'b0;
    inv_en = 1'b1;
    step();

    // Table-driven transfers; other targets ack during wait states
    for (int i = 0; i < 7; i++) begin
      m_stb_i = 1'b1; m_we_i = vecs[i].we; m_sel_i = vecs[i].sel;
      m_adr_i = vecs[i].adr; m_dat_i = vecs[i].dat; m_byte_i = vecs[i].be;
      s_dat_i = build_dat(vecs[i].sel, vecs[i].rdata);
      s_ack_i = '0;
      step();
      chk("c1 fields", 32'({s_we_o, s_adr_o, s_byte_o}), 32'({vecs[i].we, vecs[i].adr, vecs[i].be}));
      chk("c1 wdat", 32'(s_dat_o), 32'(vecs[i].dat));
      for (int c = 1; c <= 1 + vecs[i].waits; c++) begin
        chk("busy stb", 32'(s_stb_o), 32'(vecs[i].exp_stb));
        chk("busy ack", 32'({m_ack_o, m_err_o}), 32'h0);
        s_ack_i = (c == 1 + vecs[i].waits) ? vecs[i].exp_stb : ~vecs[i].exp_stb;
        step();
      end
      chk("done ack", 32'({m_ack_o, m_err_o}), 32'h2);
      chk("done stb", 32'(s_stb_o), 32'h0);
      chk("done mdat", 32'(m_dat_o), 32'(vecs[i].exp_mdat));
      m_stb_i = 1'b0; s_ack_i = 8'hFF;
      step();
      chk("post ack", 32'({m_ack_o, m_err_o, s_stb_o}), 32'h0);
      step();
      chk("idle ack", 32'({m_ack_o, s_stb_o}), 32'h0);
      chk("idle mdat", 32'(m_dat_o), 32'(vecs[i].exp_mdat));
      s_ack_i = '0;
    end

    // Back-to-back reads of targets 0 then 7 with m_stb_i held high
    s_dat_i = build_dat(3'd0, 16'hC0DE);
    s_dat_i[112 +: 16] = 16'h7E57;
    s_ack_i = 8'h81; m_stb_i = 1'b1; m_we_i = 1'b0; m_sel_i = 3'd0;
    step();
    chk("b2b c1 stb", 32'(s_stb_o), 32'h01);
    m_sel_i = 3'd7;
    step();
    chk("b2b c2 ack", 32'(m_ack_o), 32'h1);
    chk("b2b c2 mdat", 32'(m_dat_o), 32'hC0DE);
    step();
    chk("b2b c3 stb", 32'({m_ack_o, s_stb_o}), 32'h0);
    step();
    chk("b2b c4 stb", 32'(s_stb_o), 32'h80);
    step();
    chk("b2b c5 ack", 32'(m_ack_o), 32'h1);
    chk("b2b c5 mdat", 32'(m_dat_o), 32'h7E57);
    m_stb_i = 1'b0;
    step(); step();
    chk("b2b c7 idle", 32'({m_ack_o, s_stb_o}), 32'h0);
    s_ack_i = '0;

    // Reset in cycle 2 of a waiting transfer, with a coincident ack
    m_stb_i = 1'b1; m_we_i = 1'b0; m_sel_i = 3'd1; m_adr_i = 16'h4321;
    s_dat_i = build_dat(3'd1, 16'hBAD0);
    step();
    chk("rst c1 stb", 32'(s_stb_o), 32'h02);
    m_stb_i = 1'b0;
    step();
    rst = 1'b1; s_ack_i = 8'h02;
    step();
    chk("rst stb", 32'(s_stb_o), 32'h0);
    chk("rst ackerr", 32'({m_ack_o, m_err_o}), 32'h0);
    chk("rst mdat", 32'(m_dat_o), 32'h0);
    chk("rst sadr", 32'(s_adr_o), 32'h0);
    rst = 1'b0; s_ack_i = 8'h02;
    step();
    chk("rst c4 ackerr", 32'({m_ack_o, m_err_o, s_stb_o}), 32'h0);
    s_ack_i = '0; m_stb_i = 1'b1; m_sel_i = 3'd6;
    step();
    chk("rst idle stb", 32'(s_stb_o), 32'h40);
    m_stb_i = 1'b0; s_ack_i = 8'h40;
    step();
    chk("rst idle ack", 32'(m_ack_o), 32'h1);
    s_ack_i = '0;
    step();

    // Unresponsive target 3
    m_stb_i = 1'b1; m_we_i = 1'b0; m_sel_i = 3'd3; m_adr_i = 16'h0300;
    s_dat_i = build_dat(3'd3, 16'h3C3C); s_ack_i = '0;
    step();
    m_stb_i = 1'b0;
`ifdef BUS_DEMUX_TIMEOUT_EN
    err_cnt = 0; err_cyc = -1; bad = 0;
    for (int c = 1; c <= 40; c++) begin
      if (m_err_o) begin
        err_cnt++;
        if (err_cyc < 0) err_cyc = c;
      end
      if (m_ack_o) bad++;
      step();
    end
    chk("to err count", 32'(err_cnt), 32'd1);
    chk("to err cycle", 32'(err_cyc), 32'(TB_TO + 1));
    chk("to ack never", 32'(bad), 32'd0);
    chk("to mdat", 32'(m_dat_o), 32'hFFFF);
`else
    err_cnt = 0; bad = 0; err_cyc = 0;
    for (int c = 1; c <= 300; c++) begin
      if (m_err_o) err_cnt++;
      if (m_ack_o) bad++;
      if (c == 300) s_ack_i = 8'h08;
      step();
    end
    chk("long ack early", 32'(bad), 32'd0);
    chk("long ack c301", 32'(m_ack_o), 32'h1);
    chk("long mdat", 32'(m_dat_o), 32'h3C3C);
    s_ack_i = '0;
    for (int c = 0; c < 4; c++) begin
      if (m_err_o) err_cnt++;
      if (m_ack_o) err_cyc++;
      step();
    end
    chk("long err never", 32'(err_cnt), 32'd0);
    chk("long ack once", 32'(err_cyc), 32'd1);
`endif

    inv_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global run bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/bus_demux8_16.md
# bus_demux8_16

Registered 1-to-8 bus demultiplexer carrying one 16-bit initiator port to eight target ports. It latches a request together with a 3-bit target select, then drives the strobe of exactly one target. It waits for that target's acknowledge, returns the target's read data through an 8:1 return path, and pulses a single-cycle acknowledge back to the initiator. It sits between the core's memory/IO initiator and the peripheral targets.

## Interface
- `TO_CYCLES`, default 255: BUSY cycles before the timeout abort. Range 1..255. Used only with `BUS_DEMUX_TIMEOUT_EN`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `m_stb_i` in 1: initiator request. Held high until `m_ack_o` or `m_err_o`.
- `m_we_i` in 1: 1 = write, 0 = read.
- `m_sel_i` in 3: target index, 0..7.
- `m_adr_i` in 16: address, passed to the target.
- `m_dat_i` in 16: write data.
- `m_byte_i` in 2: byte enables; [0] is the low byte, [1] is the high byte.
- `m_dat_o` out 16: read data. Valid in the `m_ack_o` cycle and held until the next capture.
- `m_ack_o` out 1: one-cycle completion pulse.
- `m_err_o` out 1: one-cycle timeout pulse.
- `s_stb_o` out 8: one-hot target strobe.
- `s_we_o` out 1, `s_adr_o` out 16, `s_dat_o` out 16, `s_byte_o` out 2: latched request fields, common to all targets.
- `s_dat_i` in 128: packed target read data; target k is on bits [16k+15:16k].
- `s_ack_i` in 8: per-target acknowledge.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If `m_stb_i`=1, capture `m_sel_i`, `m_we_i`, `m_adr_i`, `m_dat_i`, `m_byte_i` into holding registers, then go to BUSY.
  - All `s_*` outputs are driven from the holding registers. They are stable for the whole BUSY state.
- **BUSY**
  - `s_stb_o` = 1 << sel_q.
  - When `s_ack_i[sel_q]`=1: on reads, capture `s_dat_i` slice sel_q into `m_dat_o`; on writes, leave `m_dat_o` unchanged. Then go to DONE.
  - Acks on non-selected targets are ignored.
- **DONE**
  - `m_ack_o`=1 (or `m_err_o`=1 after a timeout), `s_stb_o`=0.
  - Unconditionally go to IDLE.
  - A request is accepted only in IDLE, so the initiator must drop `m_stb_i` in the ack cycle or it is re-accepted.
- **`m_stb_i` dropped during BUSY:** no abort. The transfer completes and the ack still pulses.
- **Reset values:** all outputs 0, `m_dat_o`=16'h0000, holding registers 0, state IDLE.
- **Reset mid-transfer:** the transfer is discarded, no ack or err is generated, and `s_stb_o` is 0 from the cycle after the reset edge.
- **Invariants:** `m_ack_o` and `m_err_o` are never high together. `s_stb_o` is zero or one-hot.

## Timing
- Request sampled at edge 0 in IDLE:
  - `s_stb_o` high in cycle 1.
  - A zero-wait target (ack high in cycle 1) gives `m_ack_o` in cycle 2.
  - IDLE again in cycle 3; the next request is sampled at edge 3.
- Throughput: at best one transfer per 3 cycles.
- A target inserting W wait cycles gives `m_ack_o` in cycle 2+W.
- `s_ack_i` is sampled only in BUSY, so an ack during IDLE or DONE has no effect.
- A target ack and `rst` at the same edge: reset wins.

## Configuration
- Macro: `BUS_DEMUX_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit BUSY counter clears on entry to BUSY.
  - When the count reaches `TO_CYCLES` with no selected ack, the block goes to DONE with `m_err_o`=1, `m_ack_o`=0, and `m_dat_o`=16'hFFFF on reads.
  - An ack arriving at the same edge as the count reaching `TO_CYCLES` wins, giving a normal completion.
- **Undefined:**
  - No counter; BUSY waits indefinitely.
  - `m_err_o` is tied to 0.
  - `TO_CYCLES` is unused.

## Structure
- Shared package `bus_demux_pkg` holds:
  - state encoding constants: IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - `NUM_TARGETS`=8;
  - `SEL_W`=3;
  - default `TO_CYCLES`.
- Read return path: instantiate the codebase primitive `mux8_16`, with sel=sel_q and the eight `s_dat_i` slices as inputs.
- The FSM, holding registers and timeout counter stay in the top module.

## Test plan
- Write to target 5 at adr 16'h1234, dat 16'hBEEF, byte 2'b11, target zero-wait → `s_stb_o`=8'h20 in cycle 1 with the fields matching; `m_ack_o` in cycle 2 only.
- Read target 2 with 3 wait states, slice 2 = 16'hA55A and other slices = 16'h0000 → `m_ack_o` in cycle 5 with `m_dat_o`=16'hA55A; acks on targets 0 and 7 during the wait are ignored.
- Back-to-back reads of targets 0 then 7, `m_stb_i` held continuously → the second strobe rises in cycle 4; every `s_stb_o` sample is zero or one-hot.
- Assert `rst` in cycle 2 of a waiting transfer → `s_stb_o`=0 and state IDLE after that edge; no ack or err pulse; `m_dat_o`=0.
- With `BUS_DEMUX_TIMEOUT_EN` and `TO_CYCLES`=4, read an unresponsive target 3 → `m_err_o` pulses once, `m_dat_o`=16'hFFFF, `m_ack_o` stays 0.
- Without the macro, the same stimulus with an ack at cycle 300 → `m_ack_o` in cycle 301 with the data captured; `m_err_o` is never 1.
